// File: rtl/fetch_inst_queue_pkg.sv
// fetch_inst_queue_pkg: shared widths and the queue entry record for the fetch instruction queue.
package fetch_inst_queue_pkg;
   localparam int SIZE_PC     = 32;
   localparam int SIZE_INST   = 64;
   localparam int FETCH_WIDTH = 4;
   localparam int FIQ_DEPTH   = 16;
   localparam int FIQ_PTR_W   = $clog2(FIQ_DEPTH);
   typedef struct packed {
      logic [SIZE_INST-1:0] inst;
      logic [SIZE_PC-1:0]   pc;
      logic                 taken;
      logic [SIZE_PC-1:0]   target;
   } fiq_entry_t;
endpackage

// File: rtl/fetch_queue_ram.sv
// fetch_queue_ram: DEPTH-entry storage with four write ports and four asynchronous read ports.
module fetch_queue_ram
   import fetch_inst_queue_pkg::*;
#(
   parameter int DEPTH = FIQ_DEPTH,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic [3:0]       we_i,
   input  logic [PTR_W-1:0] waddr_i [4],
   input  fiq_entry_t       wdata_i [4],
   input  logic [PTR_W-1:0] raddr_i [4],
   output fiq_entry_t       rdata_o [4]
);
   fiq_entry_t mem_q [DEPTH];
   always_ff @(posedge clk)
      for (int k = 0; k < 4; k++)
         if (we_i[k]) mem_q[waddr_i[k]] <= wdata_i[k];
   always_comb
      for (int k = 0; k < 4; k++)
         rdata_o[k] = mem_q[raddr_i[k]];
endmodule

// File: rtl/fetch_inst_queue.sv
// fetch_inst_queue: circular queue decoupling fetch from decode, up to four instructions in and out per cycle.
module fetch_inst_queue #(
   parameter int SIZE_PC     = fetch_inst_queue_pkg::SIZE_PC,
   parameter int SIZE_INST   = fetch_inst_queue_pkg::SIZE_INST,
   parameter int FETCH_WIDTH = fetch_inst_queue_pkg::FETCH_WIDTH,
   parameter int DEPTH       = fetch_inst_queue_pkg::FIQ_DEPTH,
   localparam int PTR_W      = $clog2(DEPTH),
   localparam int CNT_W      = PTR_W + 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           flush_i,
   input  logic                           enq_valid_i,
   input  logic [FETCH_WIDTH-1:0]         enq_mask_i,
   input  logic [FETCH_WIDTH*SIZE_INST-1:0] enq_bundle_i,
   input  logic [SIZE_PC-1:0]             enq_pc_i,
   input  logic [FETCH_WIDTH-1:0]         enq_taken_i,
   input  logic [FETCH_WIDTH*SIZE_PC-1:0] enq_target_i,
   output logic                           enq_ready_o,
   input  logic                           deq_ready_i,
   output logic [FETCH_WIDTH-1:0]         deq_valid_o,
   output logic [FETCH_WIDTH*SIZE_INST-1:0] deq_inst_o,
   output logic [FETCH_WIDTH*SIZE_PC-1:0] deq_pc_o,
   output logic [FETCH_WIDTH-1:0]         deq_taken_o,
   output logic [FETCH_WIDTH*SIZE_PC-1:0] deq_target_o,
   output logic [CNT_W-1:0]               count_o
);
   import fetch_inst_queue_pkg::fiq_entry_t;
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [2:0]       n_enq, n_avail;
   logic             enq_fire, deq_fire, mask_ok;
   logic [3:0]       we;
   logic [PTR_W-1:0] waddr [4];
   logic [PTR_W-1:0] raddr [4];
   fiq_entry_t       wdata [4];
   fiq_entry_t       rdata [4];
   always_comb begin
      n_enq    = enq_mask_i[0] ? (enq_mask_i[1] ? (enq_mask_i[2] ? (enq_mask_i[3] ? 3'd4 : 3'd3) : 3'd2) : 3'd1) : 3'd0;
      mask_ok  = enq_mask_i inside {4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};
      n_avail  = (count_q >= CNT_W'(4)) ? 3'd4 : 3'(count_q);
      enq_fire = enq_valid_i & enq_ready_o & ~flush_i;
      deq_fire = deq_ready_i & ~flush_i;
      tail_d   = flush_i ? '0 : tail_q + (enq_fire ? PTR_W'(n_enq) : '0);
      head_d   = flush_i ? '0 : head_q + (deq_fire ? PTR_W'(n_avail) : '0);
      count_d  = flush_i ? '0 : count_q + (enq_fire ? CNT_W'(n_enq) : '0) - (deq_fire ? CNT_W'(n_avail) : '0);
   end
   // Readiness looks only at registered occupancy so fetch never depends on decode in the same cycle.
   assign enq_ready_o = count_q <= CNT_W'(DEPTH - 4);
   assign deq_valid_o = 4'((5'd1 << n_avail) - 5'd1);
   assign count_o     = count_q;
   for (genvar k = 0; k < 4; k++) begin : g_lane
      assign we[k]    = enq_fire & (3'(k) < n_enq);
      assign waddr[k] = tail_q + PTR_W'(k);
      assign raddr[k] = head_q + PTR_W'(k);
      assign wdata[k] = '{inst: enq_bundle_i[k*SIZE_INST +: SIZE_INST], pc: enq_pc_i + SIZE_PC'(8 * k),
                          taken: enq_taken_i[k], target: enq_target_i[k*SIZE_PC +: SIZE_PC]};
      assign deq_inst_o[k*SIZE_INST +: SIZE_INST] = rdata[k].inst;
      assign deq_pc_o[k*SIZE_PC +: SIZE_PC]       = rdata[k].pc;
      assign deq_taken_o[k]                       = rdata[k].taken;
      assign deq_target_o[k*SIZE_PC +: SIZE_PC]   = rdata[k].target;
   end
   fetch_queue_ram #(.DEPTH(DEPTH)) u_ram (
      .clk    (clk),
      .we_i   (we),
      .waddr_i(waddr),
      .wdata_i(wdata),
      .raddr_i(raddr),
      .rdata_o(rdata)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end
   assert property (@(posedge clk) disable iff (reset) (enq_valid_i & ~flush_i) |-> mask_ok);
endmodule

// File: tb/tb_fetch_inst_queue.sv
// tb_fetch_inst_queue: directed and random stimulus checked against a queue-based reference model.
module tb_fetch_inst_queue;
   localparam int DEPTH = 16;
   typedef struct {
      logic [63:0] inst;
      logic [31:0] pc;
      logic        taken;
      logic [31:0] target;
   } ent_t;
   logic         clk = 0, reset = 1, flush_i = 0, enq_valid_i = 0, deq_ready_i = 0;
   logic [3:0]   enq_mask_i = 0, enq_taken_i = 0;
   logic [255:0] enq_bundle_i = 0;
   logic [31:0]  enq_pc_i = 0;
   logic [127:0] enq_target_i = 0;
   logic         enq_ready_o;
   logic [3:0]   deq_valid_o, deq_taken_o;
   logic [255:0] deq_inst_o;
   logic [127:0] deq_pc_o, deq_target_o;
   logic [4:0]   count_o;
   int checks = 0, errors = 0;
   ent_t q[$];
   fetch_inst_queue dut (
      .clk(clk), .reset(reset), .flush_i(flush_i), .enq_valid_i(enq_valid_i), .enq_mask_i(enq_mask_i),
      .enq_bundle_i(enq_bundle_i), .enq_pc_i(enq_pc_i), .enq_taken_i(enq_taken_i), .enq_target_i(enq_target_i),
      .enq_ready_o(enq_ready_o), .deq_ready_i(deq_ready_i), .deq_valid_o(deq_valid_o), .deq_inst_o(deq_inst_o),
      .deq_pc_o(deq_pc_o), .deq_taken_o(deq_taken_o), .deq_target_o(deq_target_o), .count_o(count_o)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic check_model();
      int n;
      n = q.size() < 4 ? q.size() : 4;
      chk("count", 64'(count_o), 64'(q.size()));
      chk("enq_ready", 64'(enq_ready_o), 64'(DEPTH - q.size() >= 4));
      chk("deq_valid", 64'(deq_valid_o), 64'((1 << n) - 1));
      for (int k = 0; k < n; k++) begin
         chk($sformatf("inst%0d", k), deq_inst_o[k*64 +: 64], q[k].inst);
         chk($sformatf("pc%0d", k), 64'(deq_pc_o[k*32 +: 32]), 64'(q[k].pc));
         chk($sformatf("taken%0d", k), 64'(deq_taken_o[k]), 64'(q[k].taken));
         chk($sformatf("target%0d", k), 64'(deq_target_o[k*32 +: 32]), 64'(q[k].target));
      end
   endtask
   task automatic cycle(input bit v, input logic [3:0] m, input bit r, input bit f, input logic [31:0] pc);
      int n, ones;
      bit rdy;
      ent_t e;
      enq_valid_i = v; enq_mask_i = m; deq_ready_i = r; flush_i = f; enq_pc_i = pc;
      enq_bundle_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      enq_target_i = {$urandom, $urandom, $urandom, $urandom};
      enq_taken_i = 4'($urandom);
      @(posedge clk);
      n = q.size() < 4 ? q.size() : 4;
      rdy = DEPTH - q.size() >= 4;
      if (reset || f) q.delete();
      else begin
         if (r) repeat (n) void'(q.pop_front());
         if (v && rdy) begin
            ones = 0;
            while (ones < 4 && m[ones]) ones++;
            for (int k = 0; k < ones; k++) begin
               e.inst = enq_bundle_i[k*64 +: 64];
               e.pc = pc + 32'(8 * k);
               e.taken = enq_taken_i[k];
               e.target = enq_target_i[k*32 +: 32];
               q.push_back(e);
            end
         end
      end
      #1;
      check_model();
   endtask
   initial begin
      logic [3:0] legal [4];
      legal = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      reset = 0;
      cycle(0, 0, 0, 0, 0);
      chk("rst_count", 64'(count_o), 0);
      chk("rst_ready", 64'(enq_ready_o), 1);
      chk("rst_valid", 64'(deq_valid_o), 0);
      cycle(1, 4'b1111, 0, 0, 32'h100);
      chk("pc_lane1", 64'(deq_pc_o[63:32]), 64'h108);
      chk("pc_lane3", 64'(deq_pc_o[127:96]), 64'h118);
      cycle(0, 0, 1, 0, 0);
      chk("pop_count", 64'(count_o), 0);
      cycle(1, 4'b0011, 0, 0, 32'h180);
      cycle(1, 4'b0111, 0, 0, 32'h200);
      chk("stall_count", 64'(count_o), 5);
      cycle(0, 0, 1, 0, 0);
      chk("tail_valid", 64'(deq_valid_o), 64'b0001);
      chk("tail_pc", 64'(deq_pc_o[31:0]), 64'h210);
      cycle(0, 0, 1, 0, 0);
      repeat (3) cycle(1, 4'b1111, 0, 0, $urandom & ~32'h7);
      chk("fill12_ready", 64'(enq_ready_o), 1);
      cycle(1, 4'b0001, 0, 0, 32'h400);
      chk("fill13_count", 64'(count_o), 13);
      chk("fill13_ready", 64'(enq_ready_o), 0);
      cycle(1, 4'b1111, 0, 0, 32'h500);
      chk("full_ignored", 64'(count_o), 13);
      repeat (4) cycle(0, 0, 1, 0, 0);
      cycle(0, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) begin
         cycle(1, 4'b1111, 0, 0, 32'h1000 + 32'(i * 32));
         cycle(0, 0, 1, 0, 0);
      end
      cycle(1, 4'b0011, 0, 0, 32'h2000);
      cycle(0, 0, 1, 0, 0);
      cycle(1, 4'b1111, 0, 0, 32'h3000);
      chk("wrap_pc3", 64'(deq_pc_o[127:96]), 64'h3018);
      cycle(0, 0, 1, 0, 0);
      chk("wrap_empty", 64'(count_o), 0);
      cycle(1, 4'b1111, 0, 0, 32'h4000);
      cycle(1, 4'b1111, 0, 0, 32'h4020);
      chk("pre_flush", 64'(count_o), 8);
      cycle(1, 4'b1111, 1, 1, 32'h4040);
      chk("flush_count", 64'(count_o), 0);
      chk("flush_valid", 64'(deq_valid_o), 0);
      chk("flush_ready", 64'(enq_ready_o), 1);
      for (int i = 0; i < 400; i++)
         cycle($urandom_range(0, 3) != 0, legal[$urandom_range(0, 3)], $urandom_range(0, 2) == 0,
               $urandom_range(0, 40) == 0, $urandom & ~32'h7);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
